// File: rtl/sa_autosa_csb_regfile_pkg.sv
// rtl/sa_autosa_csb_regfile_pkg.sv - register map constants for the AUTOSA CSB register target
package sa_autosa_csb_pkg;

  typedef logic [31:0] csb_word_t;

  localparam int RD_LAT_MAX = 4;

  localparam logic [15:0] ADDR_ID       = 16'h0000;
  localparam logic [15:0] ADDR_CTRL     = 16'h0001;
  localparam logic [15:0] ADDR_STATUS   = 16'h0002;
  localparam logic [15:0] ADDR_CFG_BASE = 16'h0003;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ADDR_ERR = 2;

  function automatic logic [15:0] cfg_addr(input int k);
    return ADDR_CFG_BASE + 16'(k);
  endfunction

endpackage

// File: rtl/sa_autosa_csb_regfile_if.sv
// rtl/sa_autosa_csb_regfile_if.sv - CSB request/response link between bridge and register target
interface sa_autosa_csb_regfile_if;
  import sa_autosa_csb_pkg::*;

  logic        csb2autosa_valid;
  logic        csb2autosa_ready;
  logic [15:0] csb2autosa_addr;
  csb_word_t   csb2autosa_wdat;
  logic        csb2autosa_write;
  logic        csb2autosa_nposted;
  logic        autosa2csb_valid;
  csb_word_t   autosa2csb_data;

  modport master (
    output csb2autosa_valid, csb2autosa_addr, csb2autosa_wdat, csb2autosa_write, csb2autosa_nposted,
    input  csb2autosa_ready, autosa2csb_valid, autosa2csb_data
  );

  modport slave (
    input  csb2autosa_valid, csb2autosa_addr, csb2autosa_wdat, csb2autosa_write, csb2autosa_nposted,
    output csb2autosa_ready, autosa2csb_valid, autosa2csb_data
  );

endinterface

// File: rtl/sa_autosa_csb_rd_pipe.sv
// rtl/sa_autosa_csb_rd_pipe.sv - fixed-latency read response delay line with pending flag
module sa_autosa_csb_rd_pipe
  import sa_autosa_csb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      pclk,
  input  logic      prst,
  input  logic      i_rd_accept,
  input  csb_word_t i_rd_data,
  output logic      o_pending,
  output logic      o_valid,
  output csb_word_t o_data
);

  localparam int DEPTH = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  logic [DEPTH-1:0] r_vld;
  csb_word_t        r_dat [DEPTH];

  // Data only advances with its token, so the last stage holds the previous response.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_rd_accept;
      if (i_rd_accept) r_dat[0] <= i_rd_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // The last stage is excluded so a new read can be accepted in the response cycle.
  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) o_pending = o_pending | r_vld[i];
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_data  = r_dat[DEPTH-1];

endmodule

// File: rtl/sa_autosa_csb_regfile.sv
// rtl/sa_autosa_csb_regfile.sv - CSB register target: decode, register bank, core start/busy/done
module sa_autosa_csb_regfile
  import sa_autosa_csb_pkg::*;
#(
  parameter int          NUM_CFG  = 8,
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] ID_VALUE = 32'h5A5A_0001
) (
  input  logic                     pclk,
  input  logic                     prst,
  sa_autosa_csb_regfile_if.slave   csb,
  input  logic                     core_done,
  output logic                     core_start,
  output logic                     core_busy,
  output logic [NUM_CFG*32-1:0]    cfg_out,
  output logic                     intr
);

  logic                     w_accept, w_wr, w_rd, w_in_range, w_rd_pending;
  logic                     w_ctrl_wr, w_stat_wr, w_start_ok, w_irq_en_nxt, w_done_nxt;
  logic                     w_unused;
  logic [NUM_CFG-1:0]       w_cfg_hit;
  csb_word_t                w_rd_data;
  logic [NUM_CFG-1:0][31:0] r_cfg;
  logic                     r_irq_en, r_done, r_addr_err, r_busy, r_start, r_intr;

  assign csb.csb2autosa_ready = ~w_rd_pending;
  assign w_accept  = csb.csb2autosa_valid & csb.csb2autosa_ready;
  assign w_wr      = w_accept & csb.csb2autosa_write;
  assign w_rd      = w_accept & ~csb.csb2autosa_write;
  assign w_unused  = csb.csb2autosa_nposted;

  always_comb begin
    w_cfg_hit = '0;
    for (int k = 0; k < NUM_CFG; k++) w_cfg_hit[k] = (csb.csb2autosa_addr == cfg_addr(k));
  end

  assign w_in_range = (csb.csb2autosa_addr <= ADDR_STATUS) | (|w_cfg_hit);
  assign w_ctrl_wr  = w_wr & (csb.csb2autosa_addr == ADDR_CTRL);
  assign w_stat_wr  = w_wr & (csb.csb2autosa_addr == ADDR_STATUS);

  always_comb begin
    w_rd_data = '0;
    case (csb.csb2autosa_addr)
      ADDR_ID:     w_rd_data = ID_VALUE;
      ADDR_CTRL:   w_rd_data[CTRL_IRQ_EN] = r_irq_en;
      ADDR_STATUS: begin
        w_rd_data[STAT_BUSY]     = r_busy;
        w_rd_data[STAT_DONE]     = r_done;
        w_rd_data[STAT_ADDR_ERR] = r_addr_err;
      end
      default: begin
        for (int k = 0; k < NUM_CFG; k++) if (w_cfg_hit[k]) w_rd_data = r_cfg[k];
      end
    endcase
  end

  // A done arriving with a START is retired first, so the START is honoured.
  assign w_start_ok   = w_ctrl_wr & csb.csb2autosa_wdat[CTRL_START] & (~r_busy | core_done);
  assign w_irq_en_nxt = w_ctrl_wr ? csb.csb2autosa_wdat[CTRL_IRQ_EN] : r_irq_en;
  assign w_done_nxt   = core_done | (r_done & ~(w_stat_wr & csb.csb2autosa_wdat[STAT_DONE]));

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_cfg      <= '0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CFG; k++) if (w_wr & w_cfg_hit[k]) r_cfg[k] <= csb.csb2autosa_wdat;
      r_irq_en   <= w_irq_en_nxt;
      r_done     <= w_done_nxt;
      r_addr_err <= (w_accept & ~w_in_range) |
                    (r_addr_err & ~(w_stat_wr & csb.csb2autosa_wdat[STAT_ADDR_ERR]));
      r_busy     <= w_start_ok | (r_busy & ~core_done);
      r_start    <= w_start_ok;
      r_intr     <= w_done_nxt & w_irq_en_nxt;
    end
  end

  assign core_start = r_start;
  assign core_busy  = r_busy;
  assign cfg_out    = r_cfg;
  assign intr       = r_intr;

  sa_autosa_csb_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .pclk        (pclk),
    .prst        (prst),
    .i_rd_accept (w_rd),
    .i_rd_data   (w_rd_data),
    .o_pending   (w_rd_pending),
    .o_valid     (csb.autosa2csb_valid),
    .o_data      (csb.autosa2csb_data)
  );

endmodule

// File: tb/tb_sa_autosa_csb_regfile.sv
// tb/tb_sa_autosa_csb_regfile.sv - two targets (RD_LAT 1 and 3) on one stimulus, checked against a register-map model
`timescale 1ns/1ps
module tb_sa_autosa_csb_regfile;
  import sa_autosa_csb_pkg::*;

  localparam int          NCFG = 8;
  localparam logic [31:0] ID   = 32'h5A5A_0001;

  logic clk, prst;
  logic b_valid, b_write, b_done;
  logic [15:0] b_addr;
  logic [31:0] b_wdat;
  logic start1, busy1, intr1, start3, busy3, intr3;
  logic [NCFG*32-1:0] cfg1, cfg3;

  sa_autosa_csb_regfile_if if1();
  sa_autosa_csb_regfile_if if3();

  assign if1.csb2autosa_valid = b_valid;   assign if3.csb2autosa_valid = b_valid;
  assign if1.csb2autosa_addr  = b_addr;    assign if3.csb2autosa_addr  = b_addr;
  assign if1.csb2autosa_wdat  = b_wdat;    assign if3.csb2autosa_wdat  = b_wdat;
  assign if1.csb2autosa_write = b_write;   assign if3.csb2autosa_write = b_write;
  assign if1.csb2autosa_nposted = b_write; assign if3.csb2autosa_nposted = ~b_write;

  sa_autosa_csb_regfile #(.NUM_CFG(NCFG), .RD_LAT(1), .ID_VALUE(ID)) u_dut1 (
    .pclk(clk), .prst(prst), .csb(if1.slave), .core_done(b_done),
    .core_start(start1), .core_busy(busy1), .cfg_out(cfg1), .intr(intr1));

  sa_autosa_csb_regfile #(.NUM_CFG(NCFG), .RD_LAT(3), .ID_VALUE(ID)) u_dut3 (
    .pclk(clk), .prst(prst), .csb(if3.slave), .core_done(b_done),
    .core_start(start3), .core_busy(busy3), .cfg_out(cfg3), .intr(intr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCFG-1:0][31:0] cfg;
    logic irq, done, aerr, busy, start, intr, pend, ov;
    logic [31:0] due, rsp, od;
  } mst_t;

  mst_t m1, m3;
  int   m_cyc;
  int   n_chk, n_err;
  bit   cmp_on;

  function automatic logic [31:0] reg_value(input mst_t s, input logic [15:0] a);
    int idx;
    idx = int'(a) - 3;
    if (a == 16'd0) return ID;
    if (a == 16'd1) return {30'd0, s.irq, 1'b0};
    if (a == 16'd2) return {29'd0, s.aerr, s.done, s.busy};
    if (idx >= 0 && idx < NCFG) return s.cfg[idx];
    return 32'd0;
  endfunction

  // One clock of the register target seen from its pins; c is the cycle ending at this edge.
  function automatic mst_t step(input mst_t s, input int lat, input int c, input logic rst,
                                input logic v, input logic w, input logic [15:0] a,
                                input logic [31:0] d, input logic dn);
    mst_t n;
    logic acc, wr_ctrl, wr_stat;
    int   idx;
    if (rst) return '0;
    n      = s;
    n.ov   = s.pend && (32'(c + 1) == s.due);
    if (n.ov) n.od = s.rsp;
    n.pend = s.pend && (32'(c + 1) < s.due);
    acc    = v && !s.pend;
    idx    = int'(a) - 3;
    if (acc && !w) begin
      if (lat == 1) begin
        n.ov = 1'b1;
        n.od = reg_value(s, a);
      end else begin
        n.pend = 1'b1;
        n.due  = 32'(c + lat);
        n.rsp  = reg_value(s, a);
      end
    end
    wr_ctrl = acc && w && (a == 16'd1);
    wr_stat = acc && w && (a == 16'd2);
    if (acc && w && idx >= 0 && idx < NCFG) n.cfg[idx] = d;
    n.start = wr_ctrl && d[0] && (!s.busy || dn);
    n.busy  = n.start ? 1'b1 : (dn ? 1'b0 : s.busy);
    if (wr_ctrl) n.irq = d[1];
    n.done  = dn || (s.done && !(wr_stat && d[1]));
    n.aerr  = (acc && !(a < 16'(3 + NCFG))) || (s.aerr && !(wr_stat && d[2]));
    n.intr  = n.done && n.irq;
    return n;
  endfunction

  always @(posedge clk) begin
    m1    <= step(m1, 1, m_cyc, prst, b_valid, b_write, b_addr, b_wdat, b_done);
    m3    <= step(m3, 3, m_cyc, prst, b_valid, b_write, b_addr, b_wdat, b_done);
    m_cyc <= m_cyc + 1;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("d1.ready", 256'(if1.csb2autosa_ready), 256'(!m1.pend));
      chk("d1.valid", 256'(if1.autosa2csb_valid), 256'(m1.ov));
      chk("d1.data",  256'(if1.autosa2csb_data),  256'(m1.od));
      chk("d1.start", 256'(start1), 256'(m1.start));
      chk("d1.busy",  256'(busy1),  256'(m1.busy));
      chk("d1.intr",  256'(intr1),  256'(m1.intr));
      chk("d1.cfg",   256'(cfg1),   256'(m1.cfg));
      chk("d3.ready", 256'(if3.csb2autosa_ready), 256'(!m3.pend));
      chk("d3.valid", 256'(if3.autosa2csb_valid), 256'(m3.ov));
      chk("d3.data",  256'(if3.autosa2csb_data),  256'(m3.od));
      chk("d3.start", 256'(start3), 256'(m3.start));
      chk("d3.busy",  256'(busy3),  256'(m3.busy));
      chk("d3.intr",  256'(intr3),  256'(m3.intr));
      chk("d3.cfg",   256'(cfg3),   256'(m3.cfg));
    end
  end

  // Presents one request for one cycle; returns in the cycle after the accepting edge.
  task automatic req(input logic [15:0] a, input logic [31:0] d, input logic w, input logic dn);
    b_valid = 1'b1; b_addr = a; b_wdat = d; b_write = w; b_done = dn;
    @(negedge clk);
    b_valid = 1'b0; b_done = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    req(a, 32'd0, 1'b0, 1'b0);
    chk("lit.rd1_valid", 256'(if1.autosa2csb_valid), 256'(1));
    chk("lit.rd1_data",  256'(if1.autosa2csb_data),  256'(exp));
    chk("lit.rd3_ready_low", 256'(if3.csb2autosa_ready), 256'(0));
    repeat (2) @(negedge clk);
    chk("lit.rd3_valid", 256'(if3.autosa2csb_valid), 256'(1));
    chk("lit.rd3_data",  256'(if3.autosa2csb_data),  256'(exp));
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic dn);
    req(a, d, 1'b1, dn);
  endtask

  task automatic pulse_done();
    b_done = 1'b1;
    @(negedge clk);
    b_done = 1'b0;
  endtask

  initial begin
    m1 = '0; m3 = '0; m_cyc = 0; n_chk = 0; n_err = 0; cmp_on = 1'b0;
    b_valid = 1'b0; b_write = 1'b0; b_done = 1'b0; b_addr = '0; b_wdat = '0;
    prst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    prst   = 1'b0;
    chk("lit.reset_ready", 256'(if1.csb2autosa_ready), 256'(1));
    chk("lit.reset_valid", 256'(if3.autosa2csb_valid), 256'(0));
    chk("lit.reset_data",  256'(if1.autosa2csb_data),  256'(0));

    rd(16'h0, ID);
    wr(16'h3, 32'hCAFE_F00D, 1'b0);
    chk("lit.cfg0", 256'(cfg1[31:0]), 256'(32'hCAFE_F00D));
    rd(16'h3, 32'hCAFE_F00D);

    wr(16'h1, 32'h3, 1'b0);
    chk("lit.start_pulse", 256'(start1), 256'(1));
    @(negedge clk);
    chk("lit.start_end", 256'(start1), 256'(0));
    rd(16'h2, 32'h1);
    wr(16'h1, 32'h3, 1'b0);
    chk("lit.start_busy", 256'(start1), 256'(0));
    rd(16'h1, 32'h2);
    pulse_done();
    rd(16'h2, 32'h2);
    chk("lit.intr_set", 256'(intr1), 256'(1));
    wr(16'h2, 32'h2, 1'b0);
    chk("lit.intr_clr", 256'(intr1), 256'(0));
    rd(16'h2, 32'h0);

    pulse_done();
    wr(16'h2, 32'h2, 1'b1);
    rd(16'h2, 32'h2);
    wr(16'h1, 32'h3, 1'b0);
    wr(16'h1, 32'h3, 1'b1);
    chk("lit.start_with_done", 256'(start1), 256'(1));
    rd(16'h2, 32'h3);
    pulse_done();
    wr(16'h2, 32'h2, 1'b0);
    rd(16'h2, 32'h0);

    rd(16'h40, 32'h0);
    rd(16'h2, 32'h4);
    wr(16'h2, 32'h4, 1'b0);
    rd(16'h2, 32'h0);
    wr(16'h40, 32'h1234_5678, 1'b0);
    rd(16'h2, 32'h4);
    wr(16'h2, 32'h4, 1'b0);
    wr(16'hA, 32'h1357_9BDF, 1'b0);
    rd(16'hA, 32'h1357_9BDF);
    rd(16'hB, 32'h0);
    rd(16'h2, 32'h4);
    wr(16'h2, 32'h4, 1'b0);

    b_valid = 1'b1; b_write = 1'b0; b_addr = 16'h0;
    chk("lit.b2b_r0", 256'(if3.csb2autosa_ready), 256'(1));
    @(negedge clk);
    chk("lit.b2b_r1", 256'(if3.csb2autosa_ready), 256'(0));
    @(negedge clk);
    chk("lit.b2b_v2", 256'(if3.autosa2csb_valid), 256'(0));
    @(negedge clk);
    chk("lit.b2b_r3", 256'(if3.csb2autosa_ready), 256'(1));
    chk("lit.b2b_v3", 256'(if3.autosa2csb_valid), 256'(1));
    @(negedge clk);
    chk("lit.b2b_r4", 256'(if3.csb2autosa_ready), 256'(0));
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit.b2b_v6", 256'(if3.autosa2csb_valid), 256'(1));
    @(negedge clk);

    req(16'h3, 32'd0, 1'b0, 1'b0);
    prst = 1'b1;
    @(negedge clk);
    prst = 1'b0;
    chk("lit.rst_ready", 256'(if3.csb2autosa_ready), 256'(1));
    chk("lit.rst_valid", 256'(if3.autosa2csb_valid), 256'(0));
    repeat (4) @(negedge clk);
    chk("lit.rst_cfg", 256'(cfg3), 256'(0));

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
